booth_seq_arbiter: RTL and testbench

Sequencer and arbiter for the shared radix-2 Booth multiplier datapath (A, Q, Q₋₁ and M registers, plus the adder/subtractor). It accepts multiply requests from NREQ requesters and grants them round-robin. It drives the datapath's load, add/sub and shift controls for WIDTH iterations, then holds a result-valid handshake until the consumer takes the product.

---
 rtl/booth_pkg.sv | 29 ++
 rtl/booth_rr_arbiter.sv | 48 ++++
 rtl/booth_seq_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_booth_seq_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier sequencer: FSM state encoding,
// datapath control codes for the A and Q registers, and the counter-width helper.
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } boothState_t;

  // A register controls (the clear code also clears Q-1)
  localparam logic [1:0] A_HOLD = 2'b00;
  localparam logic [1:0] A_CLR  = 2'b01;
  localparam logic [1:0] A_ADD  = 2'b10;
  localparam logic [1:0] A_ASR  = 2'b11;

  // Q register controls; 2'b11 is reserved and the datapath treats it as hold
  localparam logic [1:0] Q_HOLD = 2'b00;
  localparam logic [1:0] Q_LOAD = 2'b01;
  localparam logic [1:0] Q_SHR  = 2'b10;

  // Iteration counter must hold the value WIDTH itself without wrapping
  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/booth_rr_arbiter.sv
// Round-robin pick among the multiply requesters. The search starts at the
// pointer; the pointer moves to (winner + 1) mod NREQ on each grant pulse.
module booth_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         reqValid,
  input  logic                    grantEn,
  output logic [$clog2(NREQ)-1:0] pick,
  output logic                    anyReq
);

  localparam int IdW = $clog2(NREQ);

  logic [IdW-1:0] ptr;

  // First asserted request at or after the pointer, wrapping around
  always_comb begin
    int  idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    pick   = '0;
    anyReq = |reqValid;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && reqValid[idx]) begin
        pick  = IdW'(idx);
        found = 1'b1;
      end
    end
  end

  // Pointer advances past the winner whenever the FSM accepts a grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grantEn) begin
      if (pick == IdW'(NREQ - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= pick + IdW'(1);
      end
    end
  end

endmodule

// File: rtl/booth_seq_arbiter.sv
// Sequencer and arbiter for the shared radix-2 Booth multiplier datapath.
// Grants requesters round-robin, runs WIDTH add/sub + shift iterations and
// holds the result handshake until the consumer takes the product.
//
// Build option: define BOOTH_SKIP_EVAL_EN to fold the shift into EVAL when
// the Booth pair is 00 or 11, giving data-dependent latency.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for any request; latches the round-robin winner
// LOAD  | loads M, Q from the winner, clears A and Q-1, req_ready high
// EVAL  | inspects {q0,q_neg}: A-M, A+M or nothing
// SHIFT | arithmetic shift of {A,Q,Q-1}, counts one iteration
// DONE  | product stable in {A,Q}; waits for res_ready
module booth_seq_arbiter
  import booth_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  output logic [$clog2(NREQ)-1:0] op_sel,
  output logic                    m_load,
  output logic [1:0]              a_ctrl,
  output logic [1:0]              q_ctrl,
  output logic                    add_sub,
  input  logic                    q0,
  input  logic                    q_neg,
  output logic                    busy,
  output logic                    res_valid,
  output logic [$clog2(NREQ)-1:0] res_id,
  input  logic                    res_ready
);

  localparam int IdW  = $clog2(NREQ);
  localparam int CntW = cntWidth(WIDTH);

  boothState_t     state;
  logic [IdW-1:0]  grant;
  logic [CntW-1:0] iterCnt;
  logic [CntW-1:0] iterNext;
  logic            lastIter;
  logic [IdW-1:0]  pick;
  logic            anyReq;
  logic            grantEn;

  assign iterNext = iterCnt + CntW'(1);
  assign lastIter = (iterNext == CntW'(WIDTH));
  assign grantEn  = (state == IDLE) && anyReq;
  assign op_sel   = grant;

  booth_rr_arbiter #(
    .NREQ(NREQ)
  ) uArb (
    .clk     (clk),
    .rst_n   (rst_n),
    .reqValid(req_valid),
    .grantEn (grantEn),
    .pick    (pick),
    .anyReq  (anyReq)
  );

  // Sequencing FSM with registered grant, busy and result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      iterCnt   <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            grant <= pick;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          iterCnt <= '0;
          state   <= EVAL;
        end
        EVAL: begin
`ifdef BOOTH_SKIP_EVAL_EN
          if (q0 == q_neg) begin
            iterCnt <= iterNext;
            if (lastIter) begin
              res_valid <= 1'b1;
              res_id    <= grant;
              state     <= DONE;
            end
          end else begin
            state <= SHIFT;
          end
`else
          state <= SHIFT;
`endif
        end
        SHIFT: begin
          iterCnt <= iterNext;
          if (lastIter) begin
            res_valid <= 1'b1;
            res_id    <= grant;
            state     <= DONE;
          end else begin
            state <= EVAL;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake decode: only the granted requester sees ready, and only in LOAD
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state == LOAD) && (grant == IdW'(i));
    end
  end

  // Datapath controls follow the state register; in EVAL the Booth pair from
  // the datapath's own Q bits picks the operation. req_valid and res_ready
  // never reach these outputs.
  always_comb begin
    m_load  = 1'b0;
    a_ctrl  = A_HOLD;
    q_ctrl  = Q_HOLD;
    add_sub = 1'b0;
    case (state)
      LOAD: begin
        m_load = 1'b1;
        a_ctrl = A_CLR;
        q_ctrl = Q_LOAD;
      end
      EVAL: begin
        case ({q0, q_neg})
          2'b10: begin
            a_ctrl  = A_ADD;
            add_sub = 1'b1;
          end
          2'b01: begin
            a_ctrl  = A_ADD;
            add_sub = 1'b0;
          end
          default: begin
`ifdef BOOTH_SKIP_EVAL_EN
            a_ctrl = A_ASR;
            q_ctrl = Q_SHR;
`else
            a_ctrl = A_HOLD;
`endif
          end
        endcase
      end
      SHIFT: begin
        a_ctrl = A_ASR;
        q_ctrl = Q_SHR;
      end
      default: begin
        m_load = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_seq_arbiter.sv
// Bench for booth_seq_arbiter: behavioural Booth datapath, requester driver,
// and a scoreboard fed at each grant and drained on each result handshake.
module tb_booth_seq_arbiter;

  localparam int W   = 4;
  localparam int N   = 2;
  localparam int IdW = 1;
`ifdef BOOTH_SKIP_EVAL_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam int MIN_SPACE  = SKIP ? (3 + W) : (3 + 2 * W);
  localparam int STARVE_MAX = 2 * (3 + 2 * W) + 2;

  logic           clk = 1'b0;
  logic           rstN;
  logic [N-1:0]   reqValid;
  logic [N-1:0]   reqReady;
  logic [IdW-1:0] opSel;
  logic           mLoad;
  logic [1:0]     aCtrl;
  logic [1:0]     qCtrl;
  logic           addSub;
  logic           q0;
  logic           qNeg;
  logic           busy;
  logic           resValid;
  logic [IdW-1:0] resId;
  logic           resReady;

  logic [W-1:0] opM [N];
  logic [W-1:0] opQ [N];
  int           waitCnt [N];

  logic [W:0]   dpA  = '0;
  logic [W:0]   dpM  = '0;
  logic [W-1:0] dpQ  = '0;
  logic         dpQn = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nExpect = 0;
  int nDone = 0;

  typedef struct {
    int id;
    int prod;
    int loadCyc;
    int lat;
  } exp_t;
  exp_t sb[$];

  int           ptrModel = 0;
  int           lastLoad = -1;
  logic [N-1:0] prevValid = '0;
  logic         prevResValid = 1'b0;

  booth_seq_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk      (clk),
    .rst_n    (rstN),
    .req_valid(reqValid),
    .req_ready(reqReady),
    .op_sel   (opSel),
    .m_load   (mLoad),
    .a_ctrl   (aCtrl),
    .q_ctrl   (qCtrl),
    .add_sub  (addSub),
    .q0       (q0),
    .q_neg    (qNeg),
    .busy     (busy),
    .res_valid(resValid),
    .res_id   (resId),
    .res_ready(resReady)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath; A carries one guard bit so -M of the most negative M fits
  assign q0   = dpQ[0];
  assign qNeg = dpQn;
  always @(posedge clk) begin
    if (mLoad) dpM <= {opM[opSel][W-1], opM[opSel]};
    case (aCtrl)
      2'b01: begin dpA <= '0; dpQn <= 1'b0; end
      2'b10: dpA <= addSub ? (dpA - dpM) : (dpA + dpM);
      2'b11: dpA <= {dpA[W], dpA[W:1]};
      default: ;
    endcase
    case (qCtrl)
      2'b01: dpQ <= opQ[opSel];
      2'b10: begin dpQ <= {dpA[0], dpQ[W-1:1]}; dpQn <= dpQ[0]; end
      default: ;
    endcase
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int expProduct(input logic [W-1:0] m, input logic [W-1:0] q);
    logic signed [W-1:0] ms;
    logic signed [W-1:0] qs;
    int mi;
    int qi;
    ms = m;
    qs = q;
    mi = ms;
    qi = qs;
    return (mi * qi) & ((1 << (2 * W)) - 1);
  endfunction

  // Cycles from LOAD to first res_valid: one for LOAD plus the cost of each iteration
  function automatic int expLatency(input logic [W-1:0] q);
    int   lat;
    logic prev;
    lat  = 1;
    prev = 1'b0;
    for (int i = 0; i < W; i++) begin
      lat += (!SKIP || (q[i] != prev)) ? 2 : 1;
      prev = q[i];
    end
    return lat;
  endfunction

  function automatic int rrPick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Monitor: predicts each grant, pushes the expected result, checks results
  always @(negedge clk) begin
    int   g;
    int   e;
    exp_t x;
    if (!rstN) begin
      sb.delete();
      ptrModel = 0;
      lastLoad = -1;
    end else begin
      if (reqReady != '0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (reqReady[i]) g = i;
        e = rrPick(prevValid, ptrModel);
        check("ready_onehot", int'($onehot(reqReady)), 1);
        check("grant_rr", g, e);
        check("op_sel", int'(opSel), e);
        if (lastLoad >= 0) check("spacing_min", int'((cyc - lastLoad) >= MIN_SPACE), 1);
        lastLoad  = cyc;
        ptrModel  = (g + 1) % N;
        x.id      = g;
        x.prod    = expProduct(opM[g], opQ[g]);
        x.loadCyc = cyc;
        x.lat     = expLatency(opQ[g]);
        sb.push_back(x);
      end
      if (resValid && !prevResValid) begin
        check("result_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) check("latency", cyc - sb[0].loadCyc, sb[0].lat);
      end
      if (resValid && resReady) begin
        if (sb.size() > 0) begin
          x = sb.pop_front();
          check("res_id", int'(resId), x.id);
          check("product", int'({dpA[W-1:0], dpQ}), x.prod);
          nDone++;
        end
      end
    end
    prevValid    = reqValid;
    prevResValid = resValid;
  end

  // One clock: sample ready away from the edge, then drop handshaken requests
  task automatic tick();
    logic [N-1:0] rdy;
    @(negedge clk);
    rdy = reqReady;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (reqValid[i]) begin
        waitCnt[i]++;
        if (rdy[i]) begin
          check("starve_bound", int'(waitCnt[i] <= STARVE_MAX), 1);
          reqValid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic issue(input int i, input logic [W-1:0] m, input logic [W-1:0] q);
    opM[i]      = m;
    opQ[i]      = q;
    waitCnt[i]  = 0;
    reqValid[i] = 1'b1;
    nExpect++;
  endtask

  task automatic waitIdle(input int maxCyc);
    int n;
    n = 0;
    while ((busy || reqValid != '0) && n < maxCyc) begin
      tick();
      n++;
    end
    check("idle_reached", int'(busy || reqValid != '0), 0);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_req_ready"}, int'(reqReady), 0);
    check({tag, "_m_load"}, int'(mLoad), 0);
    check({tag, "_a_ctrl"}, int'(aCtrl), 0);
    check({tag, "_q_ctrl"}, int'(qCtrl), 0);
    check({tag, "_add_sub"}, int'(addSub), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_res_valid"}, int'(resValid), 0);
    check({tag, "_res_id"}, int'(resId), 0);
    check({tag, "_op_sel"}, int'(opSel), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int expA[4] = '{0, 2, 0, 2};
    int expS[4] = '{0, 1, 0, 0};
    int issued;
    int n;

    rstN     = 1'b0;
    reqValid = '0;
    resReady = 1'b1;
    for (int i = 0; i < N; i++) begin
      opM[i] = '0;
      opQ[i] = '0;
      waitCnt[i] = 0;
    end
    repeat (3) tick();
    checkAllZero("reset");
    rstN = 1'b1;
    tick();

    // Single request, M=3 Q=0110 -> product 18
    issue(0, 4'd3, 4'd6);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin
        check("load_req_ready", int'(reqReady), 1);
        check("load_m_load", int'(mLoad), 1);
        check("load_a_ctrl", int'(aCtrl), 1);
        check("load_q_ctrl", int'(qCtrl), 1);
        check("load_busy", int'(busy), 1);
      end
`ifndef BOOTH_SKIP_EVAL_EN
      if (c >= 2 && c <= 9 && (c % 2) == 0) begin
        check("eval_a_ctrl", int'(aCtrl), expA[(c - 2) / 2]);
        if (expA[(c - 2) / 2] == 2) check("eval_add_sub", int'(addSub), expS[(c - 2) / 2]);
      end
      if (c >= 3 && c <= 9 && (c % 2) == 1) begin
        check("shift_a_ctrl", int'(aCtrl), 3);
        check("shift_q_ctrl", int'(qCtrl), 2);
      end
      if (c == 10) check("res_valid_cycle10", int'(resValid), 1);
`endif
    end
    waitIdle(30);

    // Reset in the middle of an operation aborts it
    issue(1, 4'd2, 4'd5);
    tick();
    tick();
    rstN = 1'b0;
    tick();
    checkAllZero("abort");
    rstN = 1'b1;
    nExpect--;

    // Simultaneous pairs: pointer back at 0 gives 0 then 1, twice
    repeat (2) begin
      issue(0, W'($urandom), W'($urandom));
      issue(1, W'($urandom), W'($urandom));
      waitIdle(80);
    end

    // Consumer stall in DONE
    issue(0, W'($urandom), W'($urandom));
    resReady = 1'b0;
    n = 0;
    while (!resValid && n < 40) begin
      tick();
      n++;
    end
    check("stall_reached", int'(resValid), 1);
    repeat (5) begin
      tick();
      check("stall_res_valid", int'(resValid), 1);
      check("stall_a_ctrl", int'(aCtrl), 0);
      check("stall_q_ctrl", int'(qCtrl), 0);
    end
    resReady = 1'b1;
    tick();
    check("stall_release_busy", int'(busy), 0);
    check("stall_release_valid", int'(resValid), 0);

    // Signed extreme and an all-zero multiplier
    issue(0, 4'b1000, 4'b1000);
    waitIdle(30);
    issue(1, 4'd5, 4'd0);
    waitIdle(30);

    // Random back-to-back traffic with res_ready tied high
    issued = 0;
    n = 0;
    while ((issued < 20 || reqValid != '0 || busy) && n < 3000) begin
      for (int i = 0; i < N; i++) begin
        if (!reqValid[i] && issued < 20 && $urandom_range(0, 3) == 0) begin
          issue(i, W'($urandom), W'($urandom));
          issued++;
        end
      end
      tick();
      n++;
    end
    check("random_drained", int'(issued < 20 || reqValid != '0 || busy), 0);
    repeat (3) tick();

    check("results_count", nDone, nExpect);
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
